// File: rtl/hamiltonian_tracker.sv
// Minimum-energy tracker for the PE spin array: gates sweep_ena, keeps the best
// (energy, phase, iteration) and stops on iteration budget or stall.
// Optional: TRACKER_PLATEAU_RESET_EN makes equal-energy samples clear the stall count.
module hamiltonian_tracker #(
    parameter int NUM_SPINS      = 16,
    parameter int PHASE_BITWIDTH = 4,
    parameter int H_WIDTH        = 24,
    parameter int MAX_ITER       = 4096,
    parameter int STALL_LIMIT    = 64,
    parameter int WARMUP         = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                h_valid,
    input  logic [H_WIDTH-1:0]                  h_in,
    input  logic [NUM_SPINS*PHASE_BITWIDTH-1:0] phase_in,
    output logic                                sweep_ena,
    output logic                                busy,
    output logic                                done,
    output logic                                converged,
    output logic [H_WIDTH-1:0]                  best_h,
    output logic [NUM_SPINS*PHASE_BITWIDTH-1:0] best_phase,
    output logic [$clog2(MAX_ITER+1)-1:0]       best_iter,
    output logic [$clog2(MAX_ITER+1)-1:0]       iter_count
);

    localparam int ITER_W  = $clog2(MAX_ITER + 1);
    localparam int STALL_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam int WARM_W  = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_TRACK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // With no warmup the first sample after start is already tracked.
    localparam state_t FIRST_ST = (WARMUP == 0) ? ST_TRACK : ST_WARMUP;

    state_t              state_r;
    logic [WARM_W-1:0]   warm_cnt_r;
    logic [STALL_W-1:0]  stall_cnt_r;

    logic [ITER_W-1:0]   iter_next_s;
    logic [STALL_W-1:0]  stall_next_s;
    logic [WARM_W-1:0]   warm_next_s;
    logic                improve_s;
    logic                plateau_s;
    logic                stall_hit_s;
    logic                budget_hit_s;
    logic                warm_last_s;

    // Saturating next-counter values and the improvement/termination decisions.
    always_comb begin
        improve_s = (h_in < best_h);
`ifdef TRACKER_PLATEAU_RESET_EN
        plateau_s = (h_in == best_h);
`else
        plateau_s = 1'b0;
`endif
        if (iter_count == ITER_W'(MAX_ITER)) begin
            iter_next_s = iter_count;
        end else begin
            iter_next_s = iter_count + ITER_W'(1);
        end
        if (improve_s || plateau_s) begin
            stall_next_s = '0;
        end else if (stall_cnt_r == STALL_W'(STALL_LIMIT)) begin
            stall_next_s = stall_cnt_r;
        end else begin
            stall_next_s = stall_cnt_r + STALL_W'(1);
        end
        if (warm_cnt_r == WARM_W'(WARMUP)) begin
            warm_next_s = warm_cnt_r;
        end else begin
            warm_next_s = warm_cnt_r + WARM_W'(1);
        end
        stall_hit_s  = (stall_next_s == STALL_W'(STALL_LIMIT));
        budget_hit_s = (iter_next_s == ITER_W'(MAX_ITER));
        warm_last_s  = (warm_next_s == WARM_W'(WARMUP));
    end

    // Run-control FSM with registered status and best-solution outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            sweep_ena   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            converged   <= 1'b0;
            best_h      <= '1;
            best_phase  <= '0;
            best_iter   <= '0;
            iter_count  <= '0;
            warm_cnt_r  <= '0;
            stall_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r     <= FIRST_ST;
                        sweep_ena   <= 1'b1;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        converged   <= 1'b0;
                        best_h      <= '1;
                        best_phase  <= '0;
                        best_iter   <= '0;
                        iter_count  <= '0;
                        warm_cnt_r  <= '0;
                        stall_cnt_r <= '0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_WARMUP: begin
                    if (h_valid) begin
                        warm_cnt_r <= warm_next_s;
                        if (warm_last_s) begin
                            state_r <= ST_TRACK;
                        end else begin
                            state_r <= ST_WARMUP;
                        end
                    end else begin
                        state_r <= ST_WARMUP;
                    end
                end
                ST_TRACK: begin
                    if (h_valid) begin
                        iter_count  <= iter_next_s;
                        stall_cnt_r <= stall_next_s;
                        if (improve_s) begin
                            best_h     <= h_in;
                            best_phase <= phase_in;
                            best_iter  <= iter_next_s;
                        end else begin
                            best_h <= best_h;
                        end
                        // Stall wins when both limits are reached together.
                        if (stall_hit_s || budget_hit_s) begin
                            state_r   <= ST_DONE;
                            sweep_ena <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            converged <= stall_hit_s;
                        end else begin
                            state_r <= ST_TRACK;
                        end
                    end else begin
                        state_r <= ST_TRACK;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    sweep_ena <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamiltonian_tracker.sv
// Directed scoreboard bench for hamiltonian_tracker (MAX_ITER=16, STALL_LIMIT=4, WARMUP=2).
module tb_hamiltonian_tracker;

    localparam int NS = 16, PB = 4, HW = 24, MI = 16, SL = 4, WU = 2;
    localparam int PW = NS * PB;
    localparam int IW = $clog2(MI + 1);

    logic          clk = 1'b0;
    logic          reset, start, h_valid;
    logic [HW-1:0] h_in;
    logic [PW-1:0] phase_in;
    logic          sweep_ena, busy, done, converged;
    logic [HW-1:0] best_h;
    logic [PW-1:0] best_phase;
    logic [IW-1:0] best_iter, iter_count;

    int checks = 0;
    int failures = 0;

    hamiltonian_tracker #(
        .NUM_SPINS(NS), .PHASE_BITWIDTH(PB), .H_WIDTH(HW),
        .MAX_ITER(MI), .STALL_LIMIT(SL), .WARMUP(WU)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .h_valid(h_valid),
        .h_in(h_in), .phase_in(phase_in), .sweep_ena(sweep_ena), .busy(busy),
        .done(done), .converged(converged), .best_h(best_h),
        .best_phase(best_phase), .best_iter(best_iter), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sweep, busy, done, conv;
        logic [HW-1:0] bh;
        logic [PW-1:0] bp;
        logic [IW-1:0] bi, ic;
    } exp_t;

    exp_t sb[$];

    // Reference model state: 0 idle, 1 warmup, 2 track, 3 done.
    int            m_st, m_warm, m_iter, m_stall, m_bi;
    logic          m_done, m_conv;
    logic [HW-1:0] m_bh;
    logic [PW-1:0] m_bp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic s, input logic v,
                         input logic [HW-1:0] h, input logic [PW-1:0] p);
        if (r || ((m_st == 0 || m_st == 3) && s)) begin
            m_st = r ? 0 : 1;
            m_warm = 0; m_iter = 0; m_stall = 0; m_bi = 0;
            m_done = 1'b0; m_conv = 1'b0; m_bh = '1; m_bp = '0;
        end else if (m_st == 1 && v) begin
            m_warm++;
            if (m_warm == WU) m_st = 2;
        end else if (m_st == 2 && v) begin
            if (m_iter < MI) m_iter++;
            if (h < m_bh) begin
                m_bh = h; m_bp = p; m_bi = m_iter; m_stall = 0;
`ifdef TRACKER_PLATEAU_RESET_EN
            end else if (h == m_bh) begin
                m_stall = 0;
`endif
            end else if (m_stall < SL) begin
                m_stall++;
            end
            if (m_stall == SL || m_iter == MI) begin
                m_st = 3; m_done = 1'b1; m_conv = (m_stall == SL);
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic v,
                        input logic [HW-1:0] h, input logic [PW-1:0] p);
        exp_t e;
        reset = r; start = s; h_valid = v; h_in = h; phase_in = p;
        model(r, s, v, h, p);
        e.sweep = (m_st == 1 || m_st == 2);
        e.busy  = (m_st == 1 || m_st == 2);
        e.done = m_done; e.conv = m_conv; e.bh = m_bh; e.bp = m_bp;
        e.bi = IW'(m_bi); e.ic = IW'(m_iter);
        sb.push_back(e);
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; h_valid = 1'b0;
        e = sb.pop_front();
        chk("sweep_ena",  64'(sweep_ena),  64'(e.sweep));
        chk("busy",       64'(busy),       64'(e.busy));
        chk("done",       64'(done),       64'(e.done));
        chk("converged",  64'(converged),  64'(e.conv));
        chk("best_h",     64'(best_h),     64'(e.bh));
        chk("best_phase", best_phase,      e.bp);
        chk("best_iter",  64'(best_iter),  64'(e.bi));
        chk("iter_count", 64'(iter_count), 64'(e.ic));
    endtask

    task automatic smp(input logic [HW-1:0] h, input logic [PW-1:0] p);
        step(1'b0, 1'b0, 1'b1, h, p);
    endtask

    task automatic idle_cyc();
        step(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    localparam logic [PW-1:0] TA = {NS{4'hA}};
    localparam logic [PW-1:0] TB = {NS{4'hB}};
    localparam logic [PW-1:0] TC = {NS{4'hC}};
    localparam logic [PW-1:0] TD = {NS{4'hD}};

    initial begin
        reset = 1'b1; start = 1'b0; h_valid = 1'b0; h_in = '0; phase_in = '0;
        m_st = 0;
        step(1'b1, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        chk("reset_best_h", 64'(best_h), 64'(24'hFFFFFF));

        // Reset mid-run
        step(1'b0, 1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 5; i++) smp(HW'(200 - i), TA);
        step(1'b1, 1'b0, 1'b0, '0, '0);
        chk("midrst_sweep", 64'(sweep_ena), 64'(1'b0));
        chk("midrst_iter", 64'(iter_count), 64'(5'd0));

        // Warmup discard and improvement capture, with idle gaps
        step(1'b0, 1'b1, 1'b0, '0, '0);
        smp(24'd5, TD);
        idle_cyc();
        smp(24'd3, TD);
        smp(24'd100, TA);
        chk("warm_best_h", 64'(best_h), 64'(24'd100));
        chk("warm_best_iter", 64'(best_iter), 64'(5'd1));
        chk("warm_iter", 64'(iter_count), 64'(5'd1));
        smp(24'd80, TB);
        idle_cyc();
        smp(24'd90, TC);
        step(1'b0, 1'b1, 1'b0, '0, '0);   // start while busy: ignored
        smp(24'd60, TD);
        chk("imp_best_phase", best_phase, TD);
        chk("imp_best_iter", 64'(best_iter), 64'(5'd4));
        for (int i = 0; i < 4; i++) smp(HW'(70 + i), TA);
`ifndef TRACKER_PLATEAU_RESET_EN
        chk("run1_conv", 64'(converged), 64'(1'b1));
`endif

        // Restart from DONE, then stall convergence
        step(1'b0, 1'b1, 1'b0, '0, '0);
        chk("restart_done", 64'(done), 64'(1'b0));
        chk("restart_best_h", 64'(best_h), 64'(24'hFFFFFF));
        smp(24'd1, TA);
        smp(24'd1, TA);
        smp(24'd50, TB);
        smp(24'd50, TC);
        smp(24'd70, TC);
        smp(24'd60, TC);
        smp(24'd55, TC);
`ifdef TRACKER_PLATEAU_RESET_EN
        chk("plateau_not_done", 64'(done), 64'(1'b0));
        step(1'b1, 1'b0, 1'b0, '0, '0);
`else
        chk("stall_done", 64'(done), 64'(1'b1));
        chk("stall_conv", 64'(converged), 64'(1'b1));
        chk("stall_iter", 64'(iter_count), 64'(5'd5));
        chk("stall_best_phase", best_phase, TB);
        smp(24'd2, TD);                    // ignored in DONE
`endif

        // Budget exhaustion with strictly decreasing samples
        step(1'b0, 1'b1, 1'b0, '0, '0);
        smp(24'd0, TA);
        smp(24'd0, TA);
        for (int i = 0; i < 16; i++) smp(HW'(160 - 10 * i), PW'(i + 1));
        chk("budget_done", 64'(done), 64'(1'b1));
        chk("budget_conv", 64'(converged), 64'(1'b0));
        chk("budget_best_h", 64'(best_h), 64'(24'd10));
        chk("budget_best_iter", 64'(best_iter), 64'(5'd16));
        smp(24'd0, TA);
        chk("done_hold_iter", 64'(iter_count), 64'(5'd16));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
